// File: rtl/terrain_column_renderer.sv
// Terrain column renderer: fetches one height per screen column from the front height
// buffer, paints that column sky/ground on a 160x120 VGA adapter, then handshakes a swap.
module terrain_column_renderer #(
   parameter int unsigned H_RES         = 160,
   parameter int unsigned V_RES         = 120,
   parameter int unsigned RD_LATENCY    = 1,
   parameter logic [2:0]  SKY_COLOUR    = 3'b011,
   parameter logic [2:0]  GROUND_COLOUR = 3'b010
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   output logic       rd_en,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       plot,
   output logic       busy,
   output logic       swap_req,
   input  logic       swap_ack,
   output logic       overrun
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_DRAW = 3'd3;
   localparam logic [2:0] S_SWAP = 3'd4;

   localparam logic [7:0] COL_LAST   = 8'(H_RES - 1);
   localparam logic [6:0] ROW_LAST   = 7'(V_RES - 1);
   localparam logic [7:0] HEIGHT_MAX = 8'(V_RES);
   localparam logic [7:0] WAIT_LAST  = 8'(RD_LATENCY - 1);

   logic [2:0] state, state_next;
   logic [7:0] col, col_next;
   logic [6:0] row, row_next;
   logic [7:0] wait_cnt, wait_cnt_next;
   logic [7:0] height, height_next;
   logic [7:0] x_hold;
   logic [6:0] y_hold;
   logic [2:0] colour_hold;
   logic [2:0] pixel_colour;
   logic       overrun_next;

   always_comb begin
      state_next    = state;
      col_next      = col;
      row_next      = row;
      wait_cnt_next = wait_cnt;
      height_next   = height;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = S_REQ;
               col_next   = '0;
            end
         end
         S_REQ: begin
            state_next    = S_WAIT;
            wait_cnt_next = '0;
         end
         S_WAIT: begin
            if (wait_cnt == WAIT_LAST) begin
               // Heights past the bottom row would paint nothing but sky anyway.
               height_next = (rd_data > HEIGHT_MAX) ? HEIGHT_MAX : rd_data;
               row_next    = '0;
               state_next  = S_DRAW;
            end else begin
               wait_cnt_next = wait_cnt + 8'd1;
            end
         end
         S_DRAW: begin
            if (row == ROW_LAST) begin
               if (col == COL_LAST) begin
                  state_next = S_SWAP;
               end else begin
                  col_next   = col + 8'd1;
                  state_next = S_REQ;
               end
            end else begin
               row_next = row + 7'd1;
            end
         end
         S_SWAP: begin
            if (swap_ack) begin
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign pixel_colour = ({1'b0, row} >= height) ? GROUND_COLOUR : SKY_COLOUR;

   assign rd_en      = (state == S_REQ);
   assign rd_addr    = col;
   assign plot       = (state == S_DRAW);
   assign busy       = (state != S_IDLE);
   assign swap_req   = (state == S_SWAP);
   assign vga_x      = plot ? col : x_hold;
   assign vga_y      = plot ? row : y_hold;
   assign vga_colour = plot ? pixel_colour : colour_hold;

   assign overrun_next = overrun | (start & busy);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= S_IDLE;
         col         <= '0;
         row         <= '0;
         wait_cnt    <= '0;
         height      <= '0;
         x_hold      <= '0;
         y_hold      <= '0;
         colour_hold <= '0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_next;
         col         <= col_next;
         row         <= row_next;
         wait_cnt    <= wait_cnt_next;
         height      <= height_next;
         x_hold      <= vga_x;
         y_hold      <= vga_y;
         colour_hold <= vga_colour;
         overrun     <= overrun_next;
      end
   end

endmodule

// File: tb/tb_terrain_column_renderer.sv
// Directed bench: two renderers (read latency 1 and 3) against a height-buffer model,
// with a per-pixel monitor and hand-computed checkpoints.
module tb_terrain_column_renderer;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic [1:0] swap_ack = 2'b00;
   logic [7:0] hmap [160];
   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [2:0] exp_col(input int h, input int y);
      int hc;
      hc = (h > 120) ? 120 : h;
      return (y >= hc) ? 3'b010 : 3'b011;
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_u
      localparam int unsigned LAT = (g == 0) ? 1 : 3;
      logic       rd_en, plot, busy, swap_req, overrun;
      logic [7:0] rd_addr, rd_data, vga_x;
      logic [6:0] vga_y;
      logic [2:0] vga_colour;
      logic [LAT-1:0] pv;
      logic [7:0] pa [LAT];
      int pix_cnt = 0;
      int err = 0;
      int ex = 0;
      int ey = 0;
      int last_rd = -1;

      terrain_column_renderer #(.RD_LATENCY(LAT)) u_dut (
         .clk        (clk),
         .resetn     (resetn),
         .start      (start),
         .rd_en      (rd_en),
         .rd_addr    (rd_addr),
         .rd_data    (rd_data),
         .vga_x      (vga_x),
         .vga_y      (vga_y),
         .vga_colour (vga_colour),
         .plot       (plot),
         .busy       (busy),
         .swap_req   (swap_req),
         .swap_ack   (swap_ack[g]),
         .overrun    (overrun)
      );

      // Buffer model: data valid only on the single cycle LAT after rd_en, garbage otherwise.
      assign rd_data = pv[LAT-1] ? hmap[pa[LAT-1]] : 8'hEE;

      always @(posedge clk) begin
         if (!resetn) begin
            pv <= '0;
         end else begin
            pv[0] <= rd_en;
            pa[0] <= rd_addr;
            for (int i = 1; i < int'(LAT); i++) begin
               pv[i] <= pv[i-1];
               pa[i] <= pa[i-1];
            end
         end
      end

      initial forever begin
         @(negedge clk);
         if (rd_en) begin
            if (int'(rd_addr) != ex) err++;
            if (last_rd >= 0 && cyc - last_rd != 121 + int'(LAT)) err++;
            last_rd = cyc;
         end
         if (plot) begin
            pix_cnt++;
            if (int'(vga_x) != ex || int'(vga_y) != ey) err++;
            if (vga_colour != exp_col(int'(hmap[ex]), ey)) err++;
            if (ey == 0 && cyc - last_rd != 1 + int'(LAT)) err++;
            ey++;
            if (ey == 120) begin
               ey = 0;
               if (ex == 159) begin
                  ex = 0;
                  last_rd = -1;
               end else begin
                  ex++;
               end
            end
         end
         if (!resetn) begin
            ex = 0;
            ey = 0;
            last_rd = -1;
         end
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic ack(input int idx);
      @(posedge clk); #1 swap_ack[idx] = 1'b1;
      @(posedge clk); #1 swap_ack[idx] = 1'b0;
   endtask

   initial begin
      bit ok;
      int bad;
      int base0;
      logic [7:0] tbl [8];
      tbl = '{8'd0, 8'd120, 8'd200, 8'd1, 8'd119, 8'd121, 8'd60, 8'd255};

      for (int c = 0; c < 160; c++) hmap[c] = 8'd60;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      check("rst_busy", g_u[0].busy, 0);
      check("rst_plot", g_u[0].plot, 0);
      check("rst_rd_en", g_u[0].rd_en, 0);
      check("rst_swap_req", g_u[0].swap_req, 0);
      check("rst_overrun", g_u[0].overrun, 0);
      check("rst_vga", {g_u[0].vga_x, g_u[0].vga_y, g_u[0].vga_colour}, 0);
      repeat (5) @(negedge clk);
      check("idle_no_start", g_u[0].busy, 0);

      // Frame A: flat terrain at 60
      pulse_start();
      @(negedge clk);
      check("req_busy", g_u[0].busy, 1);
      check("req_rd_en", g_u[0].rd_en, 1);
      check("req_rd_addr", g_u[0].rd_addr, 0);
      check("req_rd_en_lat3", g_u[1].rd_en, 1);
      @(negedge clk);
      check("wait_plot", g_u[0].plot, 0);
      @(negedge clk);
      check("row0_plot", g_u[0].plot, 1);
      check("row0_y", g_u[0].vga_y, 0);
      check("row0_colour", g_u[0].vga_colour, 3'b011);
      @(negedge clk);
      check("lat3_wait_plot", g_u[1].plot, 0);
      @(negedge clk);
      check("lat3_row0_plot", g_u[1].plot, 1);
      check("lat3_row0_y", g_u[1].vga_y, 0);
      repeat (57) @(negedge clk);
      check("row59_y", g_u[0].vga_y, 59);
      check("row59_colour", g_u[0].vga_colour, 3'b011);
      @(negedge clk);
      check("row60_y", g_u[0].vga_y, 60);
      check("row60_colour", g_u[0].vga_colour, 3'b010);

      ok = 0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (g_u[0].rd_en && g_u[0].rd_addr == 8'd40) begin ok = 1; break; end
      end
      check("col40_seen", ok, 1);
      pulse_start();
      @(negedge clk);
      check("overrun_set", g_u[0].overrun, 1);
      check("overrun_set_lat3", g_u[1].overrun, 1);

      ok = 0;
      for (int i = 0; i < 25000; i++) begin
         @(negedge clk);
         if (g_u[0].swap_req) begin ok = 1; break; end
      end
      check("swap_req_seen", ok, 1);
      check("frame_a_pixels", g_u[0].pix_cnt, 19200);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (g_u[0].swap_req !== 1'b1 || g_u[0].busy !== 1'b1 || g_u[0].plot !== 1'b0) bad++;
      end
      check("swap_hold", bad, 0);
      ack(0);
      @(negedge clk);
      check("swap_done_busy", g_u[0].busy, 0);
      check("swap_done_req", g_u[0].swap_req, 0);

      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (g_u[1].swap_req) begin ok = 1; break; end
      end
      check("swap_req_seen_lat3", ok, 1);
      check("frame_a_pixels_lat3", g_u[1].pix_cnt, 19200);
      ack(1);
      @(negedge clk);
      check("swap_done_busy_lat3", g_u[1].busy, 0);
      check("overrun_sticky", g_u[0].overrun, 1);
      check("monitor_err_a", g_u[0].err, 0);
      check("monitor_err_a_lat3", g_u[1].err, 0);

      // Frame B: edge heights, reset mid-frame at column 80 row 30
      for (int c = 0; c < 160; c++) hmap[c] = tbl[c % 8];
      base0 = g_u[0].pix_cnt;
      pulse_start();
      @(negedge clk);
      check("restart_busy", g_u[0].busy, 1);
      ok = 0;
      for (int i = 0; i < 12000; i++) begin
         @(negedge clk);
         if (g_u[0].plot && g_u[0].vga_x == 8'd80 && g_u[0].vga_y == 7'd29) begin
            ok = 1; break;
         end
      end
      check("col80_seen", ok, 1);
      @(posedge clk); #1 resetn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midrst_plot", g_u[0].plot, 0);
      check("midrst_rd_en", g_u[0].rd_en, 0);
      check("midrst_swap_req", g_u[0].swap_req, 0);
      check("midrst_busy", g_u[0].busy, 0);
      check("midrst_overrun", g_u[0].overrun, 0);
      check("midrst_busy_lat3", g_u[1].busy, 0);
      @(posedge clk); #1 resetn = 1'b1;
      check("frame_b_pixels", g_u[0].pix_cnt - base0, 80 * 120 + 31);
      check("monitor_err_b", g_u[0].err, 0);
      check("monitor_err_b_lat3", g_u[1].err, 0);

      // Frame C: stray acks while idle, then a full frame of edge heights
      @(posedge clk); #1 swap_ack = 2'b11;
      @(posedge clk); #1 swap_ack = 2'b00;
      @(negedge clk);
      check("stray_ack_busy", g_u[0].busy, 0);
      base0 = g_u[0].pix_cnt;
      pulse_start();
      ok = 0;
      for (int i = 0; i < 25000; i++) begin
         @(negedge clk);
         if (g_u[0].swap_req) begin ok = 1; break; end
      end
      check("swap_req_seen_c", ok, 1);
      check("frame_c_pixels", g_u[0].pix_cnt - base0, 19200);
      ack(0);
      ok = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (g_u[1].swap_req) begin ok = 1; break; end
      end
      check("swap_req_seen_c_lat3", ok, 1);
      ack(1);
      @(negedge clk);
      check("frame_c_idle", {g_u[0].busy, g_u[1].busy}, 0);
      check("frame_c_overrun", g_u[0].overrun, 0);
      check("monitor_err_c", g_u[0].err, 0);
      check("monitor_err_c_lat3", g_u[1].err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
